// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: arbitrates NUM_PORTS VDP clients onto the single 32-bit SDRAM
// command interface, schedules auto-refresh, and handles 8/16/32-bit lane steering.
// Optional build macro VRAM_ARB_ROUND_ROBIN_EN selects rotating port priority;
// without it, port 0 has the highest fixed priority.
module vram_port_arbiter #(
  parameter int unsigned NUM_PORTS      = 3,
  parameter int unsigned OP_CYCLES      = 4,
  parameter int unsigned REFRESH_CYCLES = 420
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    we,
  input  logic [2*NUM_PORTS-1:0]  size,
  input  logic [23*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0] wdata,
  output logic [NUM_PORTS-1:0]    ack,
  output logic [NUM_PORTS-1:0]    rvalid,
  output logic [31:0]             rdata,
  output logic                    busy,
  output logic                    fail,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    mem_refresh,
  output logic [20:0]             mem_addr,
  output logic [31:0]             mem_din,
  output logic [3:0]              mem_be,
  input  logic [31:0]             mem_dout,
  input  logic                    mem_busy,
  input  logic                    mem_data_ready,
  input  logic                    mem_enabled
);

  localparam int unsigned PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned OCW = $clog2(OP_CYCLES + 1);
  localparam int unsigned RCW = $clog2(REFRESH_CYCLES + 1);

  typedef enum logic [1:0] {StInit, StIdle, StOp} state_e;

  state_e               state_q, state_d;
  logic [OCW-1:0]       op_cnt_q, op_cnt_d;
  logic [RCW-1:0]       ref_cnt_q, ref_cnt_d;
  logic                 ref_pend_q, ref_pend_d;
  logic                 fail_q, fail_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d, rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d, mem_din_q, mem_din_d;
  logic                 mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, mem_refresh_q, mem_refresh_d;
  logic [20:0]          mem_addr_q, mem_addr_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic [PW-1:0]        op_port_q, op_port_d;
  logic                 op_read_q, op_read_d;
  logic [1:0]           op_size_q, op_size_d, op_lane_q, op_lane_d;

  logic          grant_vld, slot_free, ref_hit, ref_take, g_we, g_misaligned;
  logic [PW-1:0] grant_idx;
  logic [1:0]    g_size;
  logic [22:0]   g_addr;
  logic [31:0]   g_wdata, g_din, rd_shift;
  logic [3:0]    g_be;

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] last_q, last_d;

  // Rotating search starting at the port after the last granted one.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (int'(last_q) + 1 + k) % NUM_PORTS;
      if (!grant_vld && req[PW'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(cand);
      end
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[PW'(i)]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(i);
      end
    end
  end
`endif

  // Select the winning port's fields and derive lane enables and replicated write data.
  always_comb begin
    g_we    = 1'b0;
    g_size  = 2'b00;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == PW'(i)) begin
        g_we    = we[i];
        g_size  = size[2*i +: 2];
        g_addr  = addr[23*i +: 23];
        g_wdata = wdata[32*i +: 32];
      end
    end
    unique case (g_size)
      2'b00: begin
        g_be  = 4'b0001 << g_addr[1:0];
        g_din = {4{g_wdata[7:0]}};
      end
      2'b01: begin
        g_be  = g_addr[1] ? 4'b1100 : 4'b0011;
        g_din = {2{g_wdata[15:0]}};
      end
      default: begin
        g_be  = 4'b1111;
        g_din = g_wdata;
      end
    endcase
    g_misaligned = ((g_size == 2'b01) && g_addr[0]) ||
                   ((g_size == 2'b10) && (g_addr[1:0] != 2'b00));
  end

  // Right-justify the addressed lane(s) of the completing read.
  always_comb begin
    rd_shift = '0;
    unique case (op_size_q)
      2'b00:   rd_shift = {24'h0, 8'(mem_dout >> {op_lane_q, 3'b000})};
      2'b01:   rd_shift = {16'h0, 16'(mem_dout >> {op_lane_q[1], 4'b0000})};
      default: rd_shift = mem_dout;
    endcase
  end

  // Next-state: refresh timer, operation sequencing, arbitration and command issue.
  always_comb begin
    state_d       = state_q;
    op_cnt_d      = op_cnt_q;
    ref_cnt_d     = ref_cnt_q;
    fail_d        = fail_q;
    ack_d         = '0;
    rvalid_d      = '0;
    rdata_d       = rdata_q;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_refresh_d = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_be_d      = mem_be_q;
    op_port_d     = op_port_q;
    op_read_d     = op_read_q;
    op_size_d     = op_size_q;
    op_lane_d     = op_lane_q;
    ref_hit       = 1'b0;
    ref_take      = 1'b0;
    slot_free     = 1'b0;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
    last_d        = last_q;
`endif

    if (state_q != StInit) begin
      if (ref_cnt_q <= RCW'(1)) begin
        ref_cnt_d = RCW'(REFRESH_CYCLES);
        ref_hit   = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q - 1'b1;
      end
    end

    unique case (state_q)
      StInit: if (mem_enabled && !mem_busy) state_d = StIdle;
      StIdle: slot_free = 1'b1;
      StOp: begin
        op_cnt_d = op_cnt_q - 1'b1;
        // Completion edge doubles as the next arbitration slot.
        if (op_cnt_q == OCW'(1)) begin
          slot_free = 1'b1;
          state_d   = StIdle;
          op_read_d = 1'b0;
          if (op_read_q) begin
            for (int i = 0; i < NUM_PORTS; i++) rvalid_d[i] = (op_port_q == PW'(i));
            rdata_d = rd_shift;
            if (!mem_data_ready) fail_d = 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase

    if (slot_free) begin
      if (ref_pend_q) begin
        ref_take      = 1'b1;
        mem_refresh_d = 1'b1;
        state_d       = StOp;
        op_cnt_d      = OCW'(OP_CYCLES);
      end else if (grant_vld) begin
        for (int i = 0; i < NUM_PORTS; i++) ack_d[i] = (grant_idx == PW'(i));
`ifdef VRAM_ARB_ROUND_ROBIN_EN
        last_d = grant_idx;
`endif
        // Reserved size: acknowledged but never reaches the SDRAM.
        if (g_size == 2'b11) begin
          fail_d = 1'b1;
        end else begin
          state_d    = StOp;
          op_cnt_d   = OCW'(OP_CYCLES);
          mem_rd_d   = !g_we;
          mem_wr_d   = g_we;
          mem_addr_d = g_addr[22:2];
          mem_be_d   = g_be;
          mem_din_d  = g_din;
          op_port_d  = grant_idx;
          op_read_d  = !g_we;
          op_size_d  = g_size;
          op_lane_d  = g_addr[1:0];
          if (g_misaligned) fail_d = 1'b1;
        end
      end
    end

    ref_pend_d = (ref_pend_q && !ref_take) || ref_hit;
    if (ref_hit && ref_pend_q && !ref_take) fail_d = 1'b1;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StInit;
      op_cnt_q      <= '0;
      ref_cnt_q     <= RCW'(REFRESH_CYCLES);
      ref_pend_q    <= 1'b0;
      fail_q        <= 1'b0;
      ack_q         <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_refresh_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_be_q      <= '0;
      op_port_q     <= '0;
      op_read_q     <= 1'b0;
      op_size_q     <= '0;
      op_lane_q     <= '0;
    end else begin
      state_q       <= state_d;
      op_cnt_q      <= op_cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pend_q    <= ref_pend_d;
      fail_q        <= fail_d;
      ack_q         <= ack_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      mem_refresh_q <= mem_refresh_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_be_q      <= mem_be_d;
      op_port_q     <= op_port_d;
      op_read_q     <= op_read_d;
      op_size_q     <= op_size_d;
      op_lane_q     <= op_lane_d;
    end
  end

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  // Last granted port; resets so that the first search starts at port 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_q <= PW'(NUM_PORTS - 1);
    else         last_q <= last_d;
  end
`endif

  assign busy        = (state_q != StIdle);
  assign fail        = fail_q;
  assign ack         = ack_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_refresh = mem_refresh_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_be      = mem_be_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: vector table of single accesses, scoreboard for read data,
// and hand-written sequences for init, contention/refresh and error cases.
module tb_vram_port_arbiter;
  localparam int NP  = 3;
  localparam int OPC = 4;
  localparam int REF = 20;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NP-1:0]     req, we;
  logic [2*NP-1:0]   size;
  logic [23*NP-1:0]  addr;
  logic [32*NP-1:0]  wdata;
  logic [NP-1:0]     ack, rvalid;
  logic [31:0]       rdata, mem_din, mem_dout;
  logic              busy, fail, mem_rd, mem_wr, mem_refresh;
  logic [20:0]       mem_addr;
  logic [3:0]        mem_be;
  logic              mem_busy, mem_data_ready, mem_enabled;

  vram_port_arbiter #(
    .NUM_PORTS     (NP),
    .OP_CYCLES     (OPC),
    .REFRESH_CYCLES(REF)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req           (req),
    .we            (we),
    .size          (size),
    .addr          (addr),
    .wdata         (wdata),
    .ack           (ack),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .busy          (busy),
    .fail          (fail),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_refresh   (mem_refresh),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_be        (mem_be),
    .mem_dout      (mem_dout),
    .mem_busy      (mem_busy),
    .mem_data_ready(mem_data_ready),
    .mem_enabled   (mem_enabled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  size;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic [20:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          cyc;
  } sb_t;

  vec_t vecs[8];
  sb_t  sbq[$];
  sb_t  mon_item;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-data scoreboard: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      for (int p = 0; p < NP; p++) begin
        if (rvalid[p]) begin
          if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rvalid: port %0d pulsed with nothing outstanding", p);
          end else begin
            mon_item = sbq.pop_front();
            chk("rvalid_port", p, mon_item.port);
            chk("rdata", rdata, mon_item.rdata);
            chk("rvalid_latency", cyc, mon_item.cyc);
          end
        end
      end
    end
  end

  task automatic set_port(input int p, input logic w, input logic [1:0] s,
                          input logic [22:0] a, input logic [31:0] d);
    we[p]          = w;
    size[2*p +: 2] = s;
    addr[23*p +: 23] = a;
    wdata[32*p +: 32] = d;
  endtask

  task automatic wait_ack(input int p, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack[p]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: port %0d saw no ack in 40 cycles, one required", p);
      req = '0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rvalid_timeout: %0d reads outstanding, 0 required", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic do_op(input string lbl, input vec_t v);
    bit got;
    set_port(v.port, v.we, v.size, v.addr, v.wdata);
    mem_dout     = v.dout;
    req[v.port]  = 1'b1;
    wait_ack(v.port, got);
    if (got) begin
      req[v.port] = 1'b0;
      chk({lbl, "_mem_addr"}, mem_addr, v.exp_addr);
      chk({lbl, "_mem_be"}, mem_be, v.exp_be);
      if (v.we) chk({lbl, "_mem_din"}, mem_din, v.exp_din);
      chk({lbl, "_mem_wr"}, mem_wr, v.we);
      chk({lbl, "_mem_rd"}, mem_rd, !v.we);
      if (!v.we) sbq.push_back('{v.port, v.exp_rdata, cyc + OPC});
      @(negedge clk);
      chk({lbl, "_ack_once"}, ack[v.port], 1'b0);
      chk({lbl, "_cmd_pulse"}, mem_rd | mem_wr, 1'b0);
      drain();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    req    = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $fatal(1, "watchdog expired before the bench completed");
  end

  initial begin
    int  bad, n_ack, n_ref, bad_gap, bad_ord, bad_ref, last_ev, last_ref, prev, ap;
    bit  got;
    vec_t mv;

    resetn = 1'b0; req = '0; we = '0; size = '0; addr = '0; wdata = '0;
    mem_dout = '0; mem_busy = 1'b0; mem_data_ready = 1'b1; mem_enabled = 1'b0;

    //         port we   size   addr         wdata         dout          maddr       be       din           rdata
    vecs[0] = '{1, 1'b1, 2'b00, 23'h000003, 32'hFFFFFFA5, 32'h0,        21'h0,      4'b1000, 32'hA5A5A5A5, 32'h0};
    vecs[1] = '{0, 1'b0, 2'b01, 23'h000006, 32'h0,        32'h12345678, 21'h1,      4'b1100, 32'h0,        32'h00001234};
    vecs[2] = '{2, 1'b0, 2'b00, 23'h000101, 32'h0,        32'hDEADBEEF, 21'h40,     4'b0010, 32'h0,        32'h000000BE};
    vecs[3] = '{0, 1'b1, 2'b01, 23'h7FFFFC, 32'hFFFFC3C3, 32'h0,        21'h1FFFFF, 4'b0011, 32'hC3C3C3C3, 32'h0};
    vecs[4] = '{1, 1'b0, 2'b10, 23'h000010, 32'h0,        32'hCAFEF00D, 21'h4,      4'b1111, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{2, 1'b1, 2'b10, 23'h123458, 32'h89ABCDEF, 32'h0,        21'h48D16,  4'b1111, 32'h89ABCDEF, 32'h0};
    vecs[6] = '{0, 1'b0, 2'b00, 23'h000002, 32'h0,        32'h11223344, 21'h0,      4'b0100, 32'h0,        32'h00000022};
    vecs[7] = '{1, 1'b0, 2'b01, 23'h000000, 32'h0,        32'hAABBCCDD, 21'h0,      4'b0011, 32'h0,        32'h0000CCDD};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ack_rvalid", {ack, rvalid}, '0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_fail", fail, 1'b0);
    chk("rst_cmds", {mem_rd, mem_wr, mem_refresh}, 3'b000);
    chk("rst_mem_bus", {mem_addr, mem_din, mem_be}, '0);

    // INIT: request held, no ack until the SDRAM core reports enabled
    resetn = 1'b1;
    set_port(1, 1'b1, 2'b00, 23'h000003, 32'hA5);
    req[1] = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack != '0 || mem_rd || mem_wr || mem_refresh || busy !== 1'b1) bad++;
    end
    chk("init_quiet", bad, 0);
    mem_enabled = 1'b1;
    @(negedge clk);
    chk("init_busy_fall", busy, 1'b0);
    chk("init_no_ack_yet", ack, 3'b000);
    @(negedge clk);
    chk("init_first_ack", ack, 3'b010);
    req = '0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), vecs[i]);
    chk("vectors_no_fail", fail, 1'b0);

    // Contention with all ports saturating; refresh must interleave every REF cycles
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 2'b10, 23'h0, 32'h0);
    req = '1;
    n_ack = 0; n_ref = 0; bad_gap = 0; bad_ord = 0; bad_ref = 0;
    last_ev = -1; last_ref = -1; prev = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_refresh) begin
        if (n_ref >= 2 && cyc - last_ref != REF) bad_ref++;
        last_ref = cyc;
        n_ref++;
      end
      if (ack != '0) begin
        n_ack++;
        ap = -1;
        for (int p = 0; p < NP; p++) if (ack[p]) ap = p;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
        if (prev >= 0 && ap != (prev + 1) % NP) bad_ord++;
`else
        if (ap != 0) bad_ord++;
`endif
        prev = ap;
      end
      if (ack != '0 || mem_refresh) begin
        if (last_ev >= 0 && cyc - last_ev != OPC) bad_gap++;
        last_ev = cyc;
      end
    end
    req = '0;
    chk("cont_grant_order", bad_ord, 0);
    chk("cont_slot_spacing", bad_gap, 0);
    chk("cont_ack_count_ok", n_ack >= 18, 1'b1);
    chk("refresh_count_ok", n_ref >= 4, 1'b1);
    chk("refresh_interval", bad_ref, 0);
    repeat (8) @(negedge clk);
    chk("cont_no_fail", fail, 1'b0);

    // Misaligned 32-bit write: low bits ignored, fail sticky
    mv = '{0, 1'b1, 2'b10, 23'h000002, 32'h13579BDF, 32'h0, 21'h0, 4'b1111, 32'h13579BDF, 32'h0};
    do_op("mis32", mv);
    chk("mis32_fail", fail, 1'b1);
    repeat (10) @(negedge clk);
    chk("mis32_fail_sticky", fail, 1'b1);
    do_reset();
    chk("fail_cleared_by_reset", fail, 1'b0);

    // Read completing without mem_data_ready
    mem_data_ready = 1'b0;
    mv = '{2, 1'b0, 2'b10, 23'h000020, 32'h0, 32'h0BADF00D, 21'h8, 4'b1111, 32'h0, 32'h0BADF00D};
    do_op("nordy", mv);
    chk("nordy_fail", fail, 1'b1);
    mem_data_ready = 1'b1;
    do_reset();

    // Reserved size: acked, no command, no rvalid, fail set
    set_port(2, 1'b0, 2'b11, 23'h000040, 32'h0);
    req[2] = 1'b1;
    wait_ack(2, got);
    if (got) begin
      chk("rsv_no_cmd", mem_rd | mem_wr, 1'b0);
      chk("rsv_fail", fail, 1'b1);
      req = '0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (mem_rd || mem_wr || rvalid != '0) bad++;
      end
      chk("rsv_quiet", bad, 0);
    end
    do_reset();

    // Reset mid-read: aborted read never produces rvalid, state back in INIT
    set_port(0, 1'b0, 2'b10, 23'h0, 32'h0);
    mem_dout = 32'hFFFFFFFF;
    req[0]   = 1'b1;
    wait_ack(0, got);
    req = '0;
    @(negedge clk);
    resetn      = 1'b0;
    mem_enabled = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b1);
    chk("abort_outputs", {ack, rvalid, mem_rd}, '0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvalid != '0) bad++;
    end
    chk("abort_no_rvalid", bad, 0);
    chk("abort_in_init", busy, 1'b1);
    mem_enabled = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_reinit_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
